// File: rtl/reg_write_sequencer.sv
// Register-file writeback sequencer for the multicycle CPU.
// Drives destination/source selects and write enable, including load waits and the two-write POP.
module reg_write_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [4:0] rt_f,
   input  logic [4:0] rd_f,
   input  logic [4:0] rs_f,
   input  logic       mem_ready,
   output logic [2:0] reg_dst_sel,
   output logic [1:0] wb_src_sel,
   output logic       reg_write,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam logic [2:0] OP_RTYPE  = 3'd0;
   localparam logic [2:0] OP_IALU   = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_JAL    = 3'd3;
   localparam logic [2:0] OP_PUSH   = 3'd4;
   localparam logic [2:0] OP_POP    = 3'd5;
   localparam logic [2:0] OP_LINKRS = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   localparam logic [2:0] DST_RT = 3'b000;
   localparam logic [2:0] DST_RD = 3'b001;
   localparam logic [2:0] DST_RA = 3'b010;
   localparam logic [2:0] DST_RS = 3'b011;
   localparam logic [2:0] DST_SP = 3'b100;

   localparam logic [1:0] SRC_ALU = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b01;
   localparam logic [1:0] SRC_PC  = 2'b10;
   localparam logic [1:0] SRC_SP  = 2'b11;

   localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_MEM = 3'd1,
      WRITE1   = 3'd2,
      WRITE2   = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t state, stateNext;

   logic [TO_W-1:0] waitCnt, waitCntNext;
   logic [2:0]      opLat;
   logic [4:0]      rtLat, rdLat, rsLat;
   logic            latchEn;

   logic [2:0] curOp;
   logic [4:0] curRt, curRd, curRs;

   logic [2:0] dstNext;
   logic [1:0] srcNext;
   logic       writeNext, busyNext, doneNext, errorNext;

   // Destination select of the first (or only) write for each op.
   function automatic logic [2:0] firstDst(input logic [2:0] o);
      case (o)
         OP_RTYPE:  firstDst = DST_RD;
         OP_JAL:    firstDst = DST_RA;
         OP_PUSH:   firstDst = DST_SP;
         OP_LINKRS: firstDst = DST_RS;
         default:   firstDst = DST_RT;
      endcase
   endfunction

   function automatic logic [1:0] firstSrc(input logic [2:0] o);
      case (o)
         OP_LOAD, OP_POP:   firstSrc = SRC_MEM;
         OP_JAL, OP_LINKRS: firstSrc = SRC_PC;
         OP_PUSH:           firstSrc = SRC_SP;
         default:           firstSrc = SRC_ALU;
      endcase
   endfunction

   // Entering WRITE1 straight from IDLE must use the live inputs, since latching happens on the same edge.
   assign curOp = (state == IDLE) ? op   : opLat;
   assign curRt = (state == IDLE) ? rt_f : rtLat;
   assign curRd = (state == IDLE) ? rd_f : rdLat;
   assign curRs = (state == IDLE) ? rs_f : rsLat;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         waitCnt     <= '0;
         opLat       <= '0;
         rtLat       <= '0;
         rdLat       <= '0;
         rsLat       <= '0;
         reg_dst_sel <= '0;
         wb_src_sel  <= '0;
         reg_write   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= stateNext;
         waitCnt     <= waitCntNext;
         reg_dst_sel <= dstNext;
         wb_src_sel  <= srcNext;
         reg_write   <= writeNext;
         busy        <= busyNext;
         done        <= doneNext;
         error       <= errorNext;
         if (latchEn) begin
            opLat <= op;
            rtLat <= rt_f;
            rdLat <= rd_f;
            rsLat <= rs_f;
         end
      end
   end

   // Next state plus the registered Moore outputs belonging to that next state.
   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      latchEn     = 1'b0;
      dstNext     = DST_RT;
      srcNext     = SRC_ALU;
      writeNext   = 1'b0;
      doneNext    = 1'b0;
      errorNext   = 1'b0;

      case (state)
         IDLE: begin
            waitCntNext = '0;
            if (start) begin
               latchEn = 1'b1;
               if (op == OP_ILLEGAL)
                  errorNext = 1'b1;
               else if (op == OP_LOAD || op == OP_POP)
                  stateNext = WAIT_MEM;
               else
                  stateNext = WRITE1;
            end
         end
         WAIT_MEM: begin
            waitCntNext = waitCnt + TO_W'(1);
            if (mem_ready) begin
               stateNext = WRITE1;
            end else if (waitCnt == TIMEOUT_LAST) begin
               stateNext = IDLE;
               errorNext = 1'b1;
            end
         end
         WRITE1:  stateNext = (opLat == OP_POP) ? WRITE2 : DONE;
         WRITE2:  stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase

      case (stateNext)
         WRITE1: begin
            dstNext = firstDst(curOp);
            srcNext = firstSrc(curOp);
            // Writes to $zero are suppressed; $ra/$sp writes always go through.
            case (dstNext)
               DST_RT:  writeNext = (curRt != 5'd0);
               DST_RD:  writeNext = (curRd != 5'd0);
               DST_RS:  writeNext = (curRs != 5'd0);
               default: writeNext = 1'b1;
            endcase
         end
         WRITE2: begin
            dstNext   = DST_SP;
            srcNext   = SRC_SP;
            writeNext = 1'b1;
         end
         DONE:    doneNext = 1'b1;
         default: ;
      endcase

      busyNext = (stateNext != IDLE);
   end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Self-checking bench: per-transaction output trace model compared every cycle, plus literal spot checks.
module tb_reg_write_sequencer;

   localparam int unsigned MEM_TIMEOUT = 15;
   localparam int unsigned TO_W        = 4;

   logic       clk = 1'b0;
   logic       reset, start, mem_ready;
   logic [2:0] op;
   logic [4:0] rt_f, rd_f, rs_f;
   logic [2:0] reg_dst_sel;
   logic [1:0] wb_src_sel;
   logic       reg_write, busy, done, error;

   always #5 clk = ~clk;

   reg_write_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rt_f(rt_f), .rd_f(rd_f), .rs_f(rs_f), .mem_ready(mem_ready),
      .reg_dst_sel(reg_dst_sel), .wb_src_sel(wb_src_sel), .reg_write(reg_write),
      .busy(busy), .done(done), .error(error)
   );

   // {busy, done, error, reg_write, wb_src_sel, reg_dst_sel}
   typedef logic [8:0] vec_t;

   int   cyc = 0;
   int   checks = 0, errors = 0;
   bit   checkEn = 1'b0;
   vec_t expAt[int];

   int         nWrites, nDone, nError, doneCyc, errCyc;
   int         writeCyc[2];
   logic [2:0] wDst[2];
   logic [1:0] wSrc[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input bit b, input bit dn, input bit er, input bit wr,
                               input logic [1:0] s, input logic [2:0] d);
      return {b, dn, er, wr, s, d};
   endfunction

   function automatic logic [2:0] dstTab(input logic [2:0] o);
      logic [2:0] t[8];
      t = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000, 3'b011, 3'b000};
      return t[o];
   endfunction

   function automatic logic [1:0] srcTab(input logic [2:0] o);
      logic [1:0] t[8];
      t = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
      return t[o];
   endfunction

   // Fills the expected output trace of one transaction starting at cycle e; returns its last cycle.
   function automatic int schedule(input int e, input logic [2:0] o, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [4:0] rs, input int k);
      int         c, waits;
      bit         isMem, ready, wr;
      logic [2:0] d;
      if (o == 3'd7) begin
         expAt[e] = mk(0, 0, 1, 0, 2'b00, 3'b000);
         return e;
      end
      c     = e;
      isMem = (o == 3'd2) || (o == 3'd5);
      if (isMem) begin
         ready = (k >= 1) && (k <= int'(MEM_TIMEOUT));
         waits = ready ? k : int'(MEM_TIMEOUT);
         for (int i = 0; i < waits; i++) expAt[c + i] = mk(1, 0, 0, 0, 2'b00, 3'b000);
         c += waits;
         if (!ready) begin
            expAt[c] = mk(0, 0, 1, 0, 2'b00, 3'b000);
            return c;
         end
      end
      d  = dstTab(o);
      wr = (d == 3'b000) ? (rt != 0) : (d == 3'b001) ? (rd != 0) : (d == 3'b011) ? (rs != 0) : 1'b1;
      expAt[c] = mk(1, 0, 0, wr, srcTab(o), d);
      c++;
      if (o == 3'd5) begin
         expAt[c] = mk(1, 0, 0, 1, 2'b11, 3'b100);
         c++;
      end
      expAt[c] = mk(1, 1, 0, 0, 2'b00, 3'b000);
      return c;
   endfunction

   // Every-cycle comparison against the model, plus pulse bookkeeping for spot checks.
   always @(negedge clk) begin
      vec_t e;
      if (checkEn) begin
         e = expAt.exists(cyc) ? expAt[cyc] : '0;
         check("outputs", int'({busy, done, error, reg_write, wb_src_sel, reg_dst_sel}), int'(e));
         if (reg_write) begin
            if (nWrites < 2) begin
               wDst[nWrites]     = reg_dst_sel;
               wSrc[nWrites]     = wb_src_sel;
               writeCyc[nWrites] = cyc;
            end
            nWrites++;
         end
         if (done) begin
            nDone++;
            doneCyc = cyc;
         end
         if (error) begin
            nError++;
            errCyc = cyc;
         end
      end
   end

   task automatic clearCounts();
      nWrites = 0; nDone = 0; nError = 0; doneCyc = -1; errCyc = -1;
      writeCyc = '{-1, -1};
   endtask

   // k: WAIT_MEM cycle (1-based) in which mem_ready is high, 0 = never; spur: start pulsed while busy.
   task automatic runOp(input logic [2:0] o, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] rs, input int k, input bit spur, output int e);
      int last;
      @(posedge clk); #1;
      e    = cyc + 1;
      last = schedule(e, o, rt, rd, rs, k);
      clearCounts();
      start = 1'b1; op = o; rt_f = rt; rd_f = rd; rs_f = rs;
      @(posedge clk); #1;
      start = 1'b0;
      op    = 3'($urandom);
      rt_f  = 5'($urandom);
      rd_f  = 5'($urandom);
      rs_f  = 5'($urandom);
      for (int i = 1; i <= last - e + 1; i++) begin
         mem_ready = (i == k);
         start     = spur && (i == 1);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      start     = 1'b0;
   endtask

   initial begin
      int e, last;
      reset = 1'b1; start = 1'b0; op = '0; rt_f = '0; rd_f = '0; rs_f = '0; mem_ready = 1'b0;
      clearCounts();
      @(posedge clk); #1;
      checkEn = 1'b1;
      check("reset_state", int'({busy, done, error, reg_write, wb_src_sel, reg_dst_sel}), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      runOp(3'd0, 5'd0, 5'd5, 5'd0, 0, 0, e);
      check("rtype_writes", nWrites, 1);
      check("rtype_dst", int'(wDst[0]), 1);
      check("rtype_src", int'(wSrc[0]), 0);
      check("rtype_write_cyc", writeCyc[0], e);
      check("rtype_done_cyc", doneCyc, e + 1);

      runOp(3'd5, 5'd8, 5'd0, 5'd0, 4, 0, e);
      check("pop_writes", nWrites, 2);
      check("pop_w1_dst", int'(wDst[0]), 0);
      check("pop_w1_src", int'(wSrc[0]), 1);
      check("pop_w2_dst", int'(wDst[1]), 4);
      check("pop_w2_src", int'(wSrc[1]), 3);
      check("pop_w1_cyc", writeCyc[0], e + 4);
      check("pop_done_cyc", doneCyc, e + 6);

      runOp(3'd3, 5'd0, 5'd0, 5'd0, 0, 0, e);
      check("jal_writes", nWrites, 1);
      check("jal_dst", int'(wDst[0]), 2);
      check("jal_src", int'(wSrc[0]), 2);

      runOp(3'd1, 5'd0, 5'd7, 5'd0, 0, 0, e);
      check("ialu_zero_writes", nWrites, 0);
      check("ialu_zero_done", nDone, 1);

      runOp(3'd2, 5'd3, 5'd0, 5'd0, 0, 0, e);
      check("load_to_error", nError, 1);
      check("load_to_err_cyc", errCyc, e + 15);
      check("load_to_writes", nWrites, 0);
      check("load_to_done", nDone, 0);

      runOp(3'd2, 5'd3, 5'd0, 5'd0, 15, 0, e);
      check("load_last_writes", nWrites, 1);
      check("load_last_cyc", writeCyc[0], e + 15);
      check("load_last_error", nError, 0);

      runOp(3'd7, 5'd1, 5'd1, 5'd1, 0, 0, e);
      check("illegal_error", nError, 1);
      check("illegal_writes", nWrites, 0);
      check("illegal_done", nDone, 0);

      runOp(3'd4, 5'd0, 5'd0, 5'd0, 0, 1, e);
      check("push_busy_writes", nWrites, 1);
      check("push_dst", int'(wDst[0]), 4);

      runOp(3'd6, 5'd1, 5'd1, 5'd0, 0, 0, e);
      check("linkrs_zero_writes", nWrites, 0);
      runOp(3'd6, 5'd0, 5'd0, 5'd9, 0, 0, e);
      check("linkrs_dst", int'(wDst[0]), 3);

      runOp(3'd0, 5'd4, 5'd0, 5'd4, 1, 0, e);
      check("rtype_rd0_writes", nWrites, 0);

      runOp(3'd5, 5'd0, 5'd0, 5'd0, 2, 0, e);
      check("pop_rt0_writes", nWrites, 1);
      check("pop_rt0_dst", int'(wDst[0]), 4);

      // Reset during WAIT_MEM of a POP, then a late mem_ready.
      @(posedge clk); #1;
      e    = cyc + 1;
      last = schedule(e, 3'd5, 5'd8, 5'd0, 5'd0, 0);
      for (int c = e + 2; c <= last; c++) expAt.delete(c);
      clearCounts();
      start = 1'b1; op = 3'd5; rt_f = 5'd8;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_writes", nWrites, 0);
      check("rst_mid_done", nDone, 0);
      check("rst_mid_error", nError, 0);

      runOp(3'd1, 5'd4, 5'd0, 5'd0, 0, 0, e);
      check("after_rst_writes", nWrites, 1);
      check("after_rst_done_cyc", doneCyc, e + 1);

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
Sequences register-file writeback for the multicycle CPU. It drives the 3-bit destination-register mux select (rt/rd/$ra/rs/$sp), the writeback data-source select and the register-file write enable. It handles single-write instructions, loads that wait on memory, and POP, which needs two writes: rt, then $sp. The control unit hands it an op at the writeback step and waits for done.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before aborting with error
TO_W, 4, width of the wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request pulse from control unit; accepted only when busy=0
op  in  3  0 RTYPE, 1 IALU, 2 LOAD, 3 JAL, 4 PUSH, 5 POP, 6 LINKRS, 7 illegal
rt_f  in  5  instruction rt field (used for zero-reg check)
rd_f  in  5  instruction rd field
rs_f  in  5  instruction rs field
mem_ready  in  1  memory read data valid
reg_dst_sel  out  3  mux select: 000 rt, 001 rd, 010 $31, 011 rs, 100 $29
wb_src_sel  out  2  00 ALU result, 01 memory data, 10 PC, 11 SP-adjusted value
reg_write  out  1  register-file write enable
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse: illegal op or memory timeout

Behaviour:
- All outputs are registered (Moore). Reset value of every output: 0. Reset also forces state to IDLE and clears the counter.
- States: IDLE, WAIT_MEM, WRITE1, WRITE2, DONE.
- IDLE: start=1 latches op, rt_f, rd_f and rs_f.
  - LOAD or POP -> WAIT_MEM.
  - op 7 -> IDLE, with error=1 next cycle, no write and no done.
  - Otherwise -> WRITE1.
- Per-op first write (dst_sel / src_sel):
  - RTYPE: 001/00.
  - IALU: 000/00.
  - LOAD: 000/01.
  - JAL: 010/10.
  - PUSH: 100/11.
  - POP: 000/01.
  - LINKRS: 011/10.
- WAIT_MEM: the counter increments each cycle.
  - mem_ready=1 -> WRITE1.
  - Otherwise, counter==MEM_TIMEOUT-1 -> IDLE with error pulse and no write.
  - mem_ready wins if it coincides with the timeout cycle.
- WRITE1: reg_write=1 for exactly one cycle with the selects above. POP -> WRITE2, else -> DONE.
- WRITE2 (POP only): dst_sel=100, src_sel=11, reg_write=1 for one cycle -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Zero-register guard: if the latched field chosen by a write (rt, rd or rs) is 0, reg_write stays 0 for that write. Selects and sequencing are unchanged. $31 and $29 writes are never suppressed.
- In IDLE: reg_dst_sel=000, wb_src_sel=00, reg_write=0.
- Latency (start sampled at edge 0):
  - Non-memory op: write at cycle 1, done at cycle 2.
  - Memory op with mem_ready seen in WAIT_MEM cycle k: write at k+1; POP second write at k+2; done after the last write.
- start while busy=1: ignored, no queueing.
- Latched fields are immune to input changes after acceptance.
- reset mid-operation: next cycle is IDLE, all outputs 0, any pending write dropped, no done.
- mem_ready outside WAIT_MEM: ignored.

Test Plan:
- Reset, then start op=0 with rd_f=5 -> cycle 1: reg_dst_sel=001, wb_src_sel=00, reg_write=1; cycle 2: done=1; busy high for cycles 1-2.
- start op=5 (POP), rt_f=8, mem_ready after 3 wait cycles -> write 1: sel=000, src=01; then write 2: sel=100, src=11; then done. Exactly 2 reg_write pulses.
- start op=3 (JAL) -> one write with sel=010, src=10. Then op=1 with rt_f=0 -> sel=000, reg_write stays 0, done still pulses.
- start op=2 (LOAD) with mem_ready held low -> error pulse after 15 WAIT_MEM cycles, no reg_write, no done, busy drops. Second run with mem_ready on the final wait cycle -> normal write.
- start op=7 -> error=1 next cycle, no write. Also: start pulsed during an active PUSH -> ignored, only one write.
- Assert reset during WAIT_MEM of a POP, then raise mem_ready -> no reg_write, no done, outputs 0. A fresh start afterwards behaves normally.
